// File: rtl/onchip_mem_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pkg
// Shared definitions for the on-chip RAM arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths
//   REQ_CPU / REQ_DMA       : requester indices (Nios II data master, DMA)
// ---------------------------------------------------------------------------
package onchip_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    // Requester index as carried by the grant / read-return tag.
    typedef logic req_idx_t;

    localparam req_idx_t REQ_CPU = 1'b0;
    localparam req_idx_t REQ_DMA = 1'b1;

endpackage : onchip_mem_pkg

// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
// One Avalon-MM requester port (word addressed, pipelined reads).
//   master modport : requester side (drives address/byteenable/read/write/
//                    writedata, receives waitrequest/readdata/readdatavalid)
//   slave modport  : arbiter side, the mirror image
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface : onchip_mem_arbiter_if

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way per-transaction round-robin arbiter with a hold input.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request per requester
//   hold         : suppresses all new grants while 1
//   grant[1:0]   : one-hot grant, combinational in the request cycle
// The last_grant register starts at REQ_DMA so REQ_CPU wins the first
// contention after reset.
// ---------------------------------------------------------------------------
module rr_arb2
    import onchip_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] grant
);

    req_idx_t   last_grant_r;
    logic [1:0] grant_s;

    // Grant decode: single requester wins outright, contention goes to the
    // requester that did not win last time; nothing is granted in reset.
    always_comb begin
        grant_s = 2'b00;
        if (!reset_n || hold) begin
            grant_s = 2'b00;
        end else begin
            case (req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = (last_grant_r == REQ_CPU) ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Remember the winner of every issued grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= REQ_DMA;
        end else if (grant_s[1]) begin
            last_grant_r <= REQ_DMA;
        end else if (grant_s[0]) begin
            last_grant_r <= REQ_CPU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant = grant_s;

endmodule : rr_arb2

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM (one-cycle read latency) between two
// Avalon-MM requesters: m0 = Nios II data master, m1 = pixel-buffer DMA.
//   clk, reset_n      : clock, asynchronous active-low reset
//   hold              : blocks new grants; an in-flight read still returns
//   m0, m1            : requester ports (slave modport of the bus interface)
//   ram_address/byteenable/chipselect/write/writedata/clken : RAM controls
//   ram_readdata      : RAM data, valid the cycle after the address cycle
// A registered tag (rd_pend_r, rd_owner_r) routes each read return to the
// requester that issued it. A cycle with read and write both set is a write.
// ---------------------------------------------------------------------------
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [BE_W-1:0]       ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    logic [1:0]        req_s;
    logic [1:0]        grant_s;
    logic              grant_any_s;
    logic              rd_start_s;
    logic [ADDR_W-1:0] mux_address_s;
    logic [BE_W-1:0]   mux_byteenable_s;
    logic [DATA_W-1:0] mux_writedata_s;
    logic              mux_write_s;
    logic              rd_pend_r;
    req_idx_t          rd_owner_r;

    assign req_s = {m1.read | m1.write, m0.read | m0.write};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .hold    (hold),
        .grant   (grant_s)
    );

    assign grant_any_s = |grant_s;

    // RAM-side mux: port 1 only when it holds the grant, port 0 otherwise
    // (including the idle case, where the RAM ignores the values).
    always_comb begin
        mux_address_s    = m0.address;
        mux_byteenable_s = m0.byteenable;
        mux_writedata_s  = m0.writedata;
        mux_write_s      = 1'b0;
        if (grant_s[1]) begin
            mux_address_s    = m1.address;
            mux_byteenable_s = m1.byteenable;
            mux_writedata_s  = m1.writedata;
            mux_write_s      = m1.write;
        end else if (grant_s[0]) begin
            mux_write_s      = m0.write;
        end else begin
            mux_write_s      = 1'b0;
        end
    end

    // A granted access that is not a write is a read needing a response.
    assign rd_start_s = grant_any_s & ~mux_write_s;

    // Read-return tag: one entry, refreshed every cycle, so reads pipeline
    // at one per cycle and reset discards whatever was pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= REQ_CPU;
        end else if (rd_start_s) begin
            rd_pend_r  <= 1'b1;
            rd_owner_r <= grant_s[1] ? REQ_DMA : REQ_CPU;
        end else begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= rd_owner_r;
        end
    end

    assign ram_address    = mux_address_s;
    assign ram_byteenable = mux_byteenable_s;
    assign ram_writedata  = mux_writedata_s;
    assign ram_write      = mux_write_s;
    assign ram_chipselect = grant_any_s;
    assign ram_clken      = 1'b1;

    // Stall every port while in reset; otherwise stall only losing requesters.
    assign m0.waitrequest = ~reset_n | (req_s[0] & ~grant_s[0]);
    assign m1.waitrequest = ~reset_n | (req_s[1] & ~grant_s[1]);

    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = rd_pend_r & (rd_owner_r == REQ_CPU);
    assign m1.readdatavalid = rd_pend_r & (rd_owner_r == REQ_DMA);

endmodule : onchip_mem_arbiter

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Bench for onchip_mem_arbiter: behavioural RAM, directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a transaction-level model (who asks, who won last, what the memory holds).
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;
    import onchip_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hold;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic          ram_clken;
    logic [DW-1:0] ram_readdata = 32'h0;

    int checks = 0;
    int errors = 0;

    onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

    onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hold           (hold),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with a one-cycle registered read.
    logic [DW-1:0] ram_mem [int];
    logic [DW-1:0] ram_cur;
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            ram_cur = ram_mem.exists(int'(ram_address)) ? ram_mem[int'(ram_address)] : 32'h0;
            if (ram_write) begin
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) ram_cur[b*8 +: 8] = ram_writedata[b*8 +: 8];
                ram_mem[int'(ram_address)] = ram_cur;
            end else begin
                ram_readdata <= ram_cur;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated at every falling edge.
    initial begin : model
        logic [DW-1:0] mem_model [int];
        logic          last_win;
        logic [1:0]    exp_valid;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] cur;
        logic          r0, w0, r1, w1, q0, q1;
        int            win;
        last_win  = 1'b1;
        exp_valid = 2'b00;
        exp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk1("rst_wait0", m0_bus.waitrequest, 1'b1);
                chk1("rst_wait1", m1_bus.waitrequest, 1'b1);
                chk1("rst_cs", ram_chipselect, 1'b0);
                chk1("rst_write", ram_write, 1'b0);
                chk1("rst_rvalid0", m0_bus.readdatavalid, 1'b0);
                chk1("rst_rvalid1", m1_bus.readdatavalid, 1'b0);
                last_win  = 1'b1;
                exp_valid = 2'b00;
            end else begin
                chk1("m_rvalid0", m0_bus.readdatavalid, exp_valid[0]);
                chk1("m_rvalid1", m1_bus.readdatavalid, exp_valid[1]);
                if (exp_valid != 2'b00) begin
                    chk32("m_rdata0", m0_bus.readdata, exp_data);
                    chk32("m_rdata1", m1_bus.readdata, exp_data);
                end
                r0 = m0_bus.read; w0 = m0_bus.write;
                r1 = m1_bus.read; w1 = m1_bus.write;
                q0 = r0 | w0;
                q1 = r1 | w1;
                win = -1;
                if (!hold) begin
                    if (q0 && q1) win = (last_win == 1'b0) ? 1 : 0;
                    else if (q0)  win = 0;
                    else if (q1)  win = 1;
                end
                chk1("m_wait0", m0_bus.waitrequest, q0 && (win != 0));
                chk1("m_wait1", m1_bus.waitrequest, q1 && (win != 1));
                chk1("m_cs", ram_chipselect, win >= 0);
                exp_valid = 2'b00;
                if (win == 0) begin
                    chk32("m_addr", 32'(ram_address), 32'(m0_bus.address));
                    chk32("m_be", 32'(ram_byteenable), 32'(m0_bus.byteenable));
                    chk1("m_we", ram_write, w0);
                    if (w0) chk32("m_wdata", ram_writedata, m0_bus.writedata);
                end else if (win == 1) begin
                    chk32("m_addr", 32'(ram_address), 32'(m1_bus.address));
                    chk32("m_be", 32'(ram_byteenable), 32'(m1_bus.byteenable));
                    chk1("m_we", ram_write, w1);
                    if (w1) chk32("m_wdata", ram_writedata, m1_bus.writedata);
                end else begin
                    chk32("m_idle_addr", 32'(ram_address), 32'(m0_bus.address));
                    chk1("m_idle_we", ram_write, 1'b0);
                end
                if (win >= 0) begin
                    logic          w;
                    logic [AW-1:0] a;
                    logic [BW-1:0] be;
                    logic [DW-1:0] d;
                    last_win = (win == 1);
                    w  = (win == 1) ? w1 : w0;
                    a  = (win == 1) ? m1_bus.address : m0_bus.address;
                    be = (win == 1) ? m1_bus.byteenable : m0_bus.byteenable;
                    d  = (win == 1) ? m1_bus.writedata : m0_bus.writedata;
                    cur = mem_model.exists(int'(a)) ? mem_model[int'(a)] : 32'h0;
                    if (w) begin
                        for (int b = 0; b < BW; b++)
                            if (be[b]) cur[b*8 +: 8] = d[b*8 +: 8];
                        mem_model[int'(a)] = cur;
                    end else begin
                        exp_valid[win] = 1'b1;
                        exp_data       = cur;
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
        if (p == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
            m0_bus.writedata = d; m0_bus.byteenable = be;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
            m1_bus.writedata = d; m1_bus.byteenable = be;
        end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drv(1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    initial begin : stim
        reset_n = 1'b0;
        hold    = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Contention right after reset: m0 first, then strict alternation.
        drv(0, 1'b1, 1'b0, 16'h0001, 32'h0, 4'hF);
        drv(1, 1'b1, 1'b0, 16'h0002, 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk32("cont_addr", 32'(ram_address), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk1("cont_wait0", m0_bus.waitrequest, k % 2 == 1);
            chk1("cont_wait1", m1_bus.waitrequest, k % 2 == 0);
            if (k > 0) chk1("cont_rvalid0", m0_bus.readdatavalid, k % 2 == 1);
            nxt();
        end
        idle();

        // Single write then read on m0.
        drv(0, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        @(negedge clk); chk1("sr_wr_wait", m0_bus.waitrequest, 1'b0);
        nxt();
        drv(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        @(negedge clk); chk1("sr_rd_wait", m0_bus.waitrequest, 1'b0);
        nxt();
        idle();
        @(negedge clk);
        chk1("sr_rvalid0", m0_bus.readdatavalid, 1'b1);
        chk32("sr_rdata", m0_bus.readdata, 32'hDEADBEEF);
        chk1("sr_rvalid1", m1_bus.readdatavalid, 1'b0);
        nxt();

        // Byte-enable merge.
        drv(0, 1'b0, 1'b1, 16'h00FF, 32'h11223344, 4'hF);
        nxt();
        idle();
        drv(1, 1'b0, 1'b1, 16'h00FF, 32'hAABBCCDD, 4'h2);
        nxt();
        idle();
        drv(0, 1'b1, 1'b0, 16'h00FF, 32'h0, 4'hF);
        nxt();
        idle();
        @(negedge clk);
        chk1("be_rvalid0", m0_bus.readdatavalid, 1'b1);
        chk32("be_rdata", m0_bus.readdata, 32'h1122CC44);
        nxt();

        // Hold blocks a pending m1 write for three cycles.
        hold = 1'b1;
        drv(1, 1'b0, 1'b1, 16'h0020, 32'h12345678, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("hold_wait1", m1_bus.waitrequest, 1'b1);
            chk1("hold_cs", ram_chipselect, 1'b0);
            nxt();
        end
        hold = 1'b0;
        @(negedge clk);
        chk1("hold_rel_wait1", m1_bus.waitrequest, 1'b0);
        chk1("hold_rel_we", ram_write, 1'b1);
        nxt();
        drv(1, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
        nxt();
        idle();
        @(negedge clk);
        chk1("hold_rvalid1", m1_bus.readdatavalid, 1'b1);
        chk32("hold_rdata", m1_bus.readdata, 32'h12345678);
        nxt();

        // Reset lands while an m0 read is in its grant cycle.
        drv(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
        @(negedge clk); chk1("rmr_cs", ram_chipselect, 1'b1);
        #4 reset_n = 1'b0;
        nxt();
        idle();
        @(negedge clk);
        chk1("rmr_rvalid0", m0_bus.readdatavalid, 1'b0);
        chk1("rmr_rvalid1", m1_bus.readdatavalid, 1'b0);
        nxt();
        reset_n = 1'b1;
        @(negedge clk);
        chk1("rmr_post_rvalid0", m0_bus.readdatavalid, 1'b0);
        chk1("rmr_post_rvalid1", m1_bus.readdatavalid, 1'b0);
        nxt();
        drv(0, 1'b1, 1'b0, 16'h0003, 32'h0, 4'hF);
        drv(1, 1'b1, 1'b0, 16'h0004, 32'h0, 4'hF);
        @(negedge clk);
        chk32("rmr_first_win", 32'(ram_address), 32'h3);
        chk1("rmr_wait1", m1_bus.waitrequest, 1'b1);
        nxt();
        idle();
        nxt();

        // Read and write together is treated as a write.
        drv(1, 1'b1, 1'b1, 16'h0005, 32'h00000005, 4'hF);
        @(negedge clk); chk1("rw_we", ram_write, 1'b1);
        nxt();
        idle();
        @(negedge clk); chk1("rw_no_rvalid1", m1_bus.readdatavalid, 1'b0);
        nxt();
        drv(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'hF);
        nxt();
        idle();
        @(negedge clk);
        chk1("rw_rvalid1", m1_bus.readdatavalid, 1'b1);
        chk32("rw_rdata", m1_bus.readdata, 32'h00000005);
        nxt();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            hold    = ($urandom_range(0, 9) == 0);
            drv(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                16'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            drv(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                16'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            nxt();
        end
        reset_n = 1'b1;
        hold    = 1'b0;
        idle();
        repeat (2) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_onchip_mem_arbiter
